// File: rtl/mul8_seq_ctrl_if.sv
// rtl/mul8_seq_ctrl_if.sv - request/result handshake and shared-adder signals for mul8_seq_ctrl
interface mul8_seq_ctrl_if #(
  parameter int WIDTH = 8
);
  logic                 start;
  logic [WIDTH-1:0]     multiplicand;
  logic [WIDTH-1:0]     multiplier;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;
  logic [WIDTH-1:0]     add_a;
  logic [WIDTH-1:0]     add_b;
  logic                 add_cin;
  logic [WIDTH-1:0]     add_s;
  logic                 add_cout;

  // master is the surrounding environment: requester plus the combinational adder
  modport master (
    output start, multiplicand, multiplier, add_s, add_cout,
    input  busy, done, product, add_a, add_b, add_cin
  );

  modport slave (
    input  start, multiplicand, multiplier, add_s, add_cout,
    output busy, done, product, add_a, add_b, add_cin
  );
endinterface

// File: rtl/mul8_seq_ctrl.sv
// rtl/mul8_seq_ctrl.sv - shift-add multiply sequencer driving one shared external adder
module mul8_seq_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  mul8_seq_ctrl_if.slave    bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [WIDTH-1:0]     r_m;
  logic [WIDTH-1:0]     r_acc;
  logic [WIDTH-1:0]     r_q;
  logic [CW-1:0]        r_cnt;
  logic [2*WIDTH-1:0]   r_product;
  logic                 w_last;
  logic [WIDTH-1:0]     w_acc_next;
  logic [WIDTH-1:0]     w_q_next;

  assign w_last     = (r_cnt == CW'(WIDTH - 1));
  // combined right shift of {cout, s, q}: carry lands in the acc MSB
  assign w_acc_next = {bus.add_cout, bus.add_s[WIDTH-1:1]};
  assign w_q_next   = {bus.add_s[0], r_q[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_next = S_ITER;
      S_ITER:  if (w_last)    w_next = S_DONE;
      S_DONE:                 w_next = S_IDLE;
      default:                w_next = S_IDLE;
    endcase
  end

  // adder operands depend only on state and registers, so the adder loop never closes combinationally
  always_comb begin
    bus.busy    = 1'b0;
    bus.done    = 1'b0;
    bus.add_a   = '0;
    bus.add_b   = '0;
    bus.add_cin = 1'b0;
    case (r_state)
      S_ITER: begin
        bus.busy  = 1'b1;
        bus.add_a = r_acc;
        bus.add_b = r_q[0] ? r_m : '0;
      end
      S_DONE: begin
        bus.busy = 1'b1;
        bus.done = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m       <= '0;
      r_acc     <= '0;
      r_q       <= '0;
      r_cnt     <= '0;
      r_product <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_m   <= bus.multiplicand;
            r_q   <= bus.multiplier;
            r_acc <= '0;
            r_cnt <= '0;
          end
        end
        S_ITER: begin
          r_acc <= w_acc_next;
          r_q   <= w_q_next;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            r_product <= {w_acc_next, w_q_next};
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.product = r_product;
endmodule
